// File: rtl/irb_pkg.sv
// Shared constants and enums for the inverted-residual block datapath.
// Pixel width, intermediate feature-map depth and arbiter state types.
package irb_pkg;

  localparam int PX_W         = 16;
  localparam int FMINT_N_ELEM = 3072;
  localparam int FMINT_ADDR_W = $clog2(FMINT_N_ELEM);

  typedef enum logic {
    IDLE,
    CLEAR
  } fmint_state_t;

  typedef enum logic {
    PRIO_WR,
    PRIO_RD
  } fmint_prio_t;

endpackage

// File: rtl/fmint_rr_arb2.sv
// Two-input round-robin grant for the FMINT writer/reader pair.
// Grant is combinational from requests; priority flips to the loser.
module fmint_rr_arb2
  import irb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_req_wr,
  input  logic i_req_rd,
  output logic o_gnt_wr,
  output logic o_gnt_rd
);

  fmint_prio_t r_prio;
  logic        w_gnt_wr;
  logic        w_gnt_rd;

  assign w_gnt_wr = i_en && i_req_wr &&
                    (!i_req_rd || r_prio == PRIO_WR);
  assign w_gnt_rd = i_en && i_req_rd && !w_gnt_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= PRIO_WR;
    end else if (w_gnt_wr) begin
      r_prio <= PRIO_RD;
    end else if (w_gnt_rd) begin
      r_prio <= PRIO_WR;
    end
  end

  assign o_gnt_wr = w_gnt_wr;
  assign o_gnt_rd = w_gnt_rd;

endmodule

// File: rtl/fmint_port_arbiter.sv
// Single-port FMINT RAM sharing between expansion writer and depthwise
// reader, with a zero-fill sweep between inverted-residual blocks.
module fmint_port_arbiter
  import irb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_start,
  output logic                    clr_busy,
  output logic                    clr_done,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [FMINT_ADDR_W-1:0] wr_addr,
  input  logic [PX_W-1:0]         wr_data,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [FMINT_ADDR_W-1:0] rd_addr,
  output logic                    rd_rvalid,
  output logic [PX_W-1:0]         rd_rdata,
  output logic [FMINT_ADDR_W-1:0] ram_addr,
  output logic [PX_W-1:0]         ram_data,
  output logic                    ram_write,
  input  logic [PX_W-1:0]         ram_res
);

  localparam int ADDR_W = FMINT_ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_END  = ADDR_W'(FMINT_N_ELEM);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FMINT_N_ELEM - 1);

  fmint_state_t      r_state;
  fmint_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_rvalid;
  logic              r_rd_oor;
  logic [ADDR_W-1:0] r_last_addr;

  logic              w_arb_en;
  logic              w_gnt_wr;
  logic              w_gnt_rd;
  logic              w_wr_inr;
  logic              w_rd_inr;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [PX_W-1:0]   w_ram_data;
  logic              w_ram_write;

  // rst_n gates the grant so ready is low while reset is held
  assign w_arb_en = rst_n && (r_state == IDLE);
  assign w_wr_inr = wr_addr < ADDR_END;
  assign w_rd_inr = rd_addr < ADDR_END;

  fmint_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_arb_en),
    .i_req_wr (wr_valid),
    .i_req_rd (rd_valid),
    .o_gnt_wr (w_gnt_wr),
    .o_gnt_rd (w_gnt_rd)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_ram_addr  = r_last_addr;
    w_ram_data  = '0;
    w_ram_write = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (clr_start) begin
          w_state_nxt = CLEAR;
        end
        unique case (1'b1)
          w_gnt_wr: begin
            w_ram_addr  = wr_addr;
            w_ram_data  = wr_data;
            w_ram_write = w_wr_inr;
          end
          w_gnt_rd: begin
            w_ram_addr = rd_addr;
          end
          default: ;
        endcase
      end
      CLEAR: begin
        w_ram_addr  = r_cnt;
        w_ram_write = 1'b1;
        if (r_cnt == ADDR_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rd_oor    <= 1'b0;
      r_last_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_done      <= w_done_nxt;
      r_rvalid    <= w_gnt_rd;
      r_rd_oor    <= w_gnt_rd && !w_rd_inr;
      r_last_addr <= w_ram_addr;
    end
  end

  assign wr_ready  = w_gnt_wr;
  assign rd_ready  = w_gnt_rd;
  assign clr_busy  = (r_state == CLEAR);
  assign clr_done  = r_done;
  assign rd_rvalid = r_rvalid;
  assign rd_rdata  = (r_rvalid && !r_rd_oor) ? ram_res : '0;
  assign ram_addr  = w_ram_addr;
  assign ram_data  = w_ram_data;
  assign ram_write = w_ram_write;

endmodule

// File: doc/fmint_port_arbiter.md
Name: fmint_port_arbiter

Overview:
- Shares the single-port intermediate-feature-map RAM between two requesters:
  - the expansion-stage writer, which produces intermediate pixels;
  - the depthwise-stage reader, which consumes them.
- Serialises their accesses with fair round-robin arbitration.
- Provides a zero-fill sweep that clears the tile between inverted-residual blocks.
- Sits between the two conv stages and the FMINT RAM, and drives the RAM's addr/data/write inputs directly.

Parameters:
- PX_W, 16, pixel width in bits (from shared package).
- FMINT_N_ELEM, 3072, number of RAM entries (from shared package).
- ADDR_W, $clog2(FMINT_N_ELEM), address width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clr_start  in  1  pulse: begin zero-fill sweep.
- clr_busy  out  1  high while the sweep runs.
- clr_done  out  1  one-cycle pulse when the sweep completes.
- wr_valid  in  1  writer request.
- wr_ready  out  1  writer grant; transfer occurs when wr_valid && wr_ready.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  PX_W  write data.
- rd_valid  in  1  reader request.
- rd_ready  out  1  reader grant.
- rd_addr  in  ADDR_W  read address.
- rd_rvalid  out  1  read data valid.
- rd_rdata  out  PX_W  read data.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_data  out  PX_W  to RAM data.
- ram_write  out  1  to RAM write.
- ram_res  in  PX_W  from RAM res; registered, valid 1 cycle after the address is presented.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE; prio = WR; sweep counter 0.
  - clr_busy, clr_done, rd_rvalid, ram_write = 0.
  - Ready outputs low while in reset.
- States: IDLE, CLEAR.
- IDLE arbitration (combinational grant, one transfer per cycle total):
  - Only wr_valid: wr_ready = 1.
  - Only rd_valid: rd_ready = 1.
  - Both valid: grant goes to the side named by prio; prio then flips to the loser.
  - A single-requester grant also sets prio to the other side.
- Ready gating:
  - wr_ready and rd_ready are never both high.
  - Both are low when no request is pending.
  - Ready depends on valid; valid must not depend on ready.
- Write grant:
  - ram_addr = wr_addr, ram_data = wr_data, ram_write = 1 in the same cycle.
- Read grant:
  - ram_addr = rd_addr, ram_write = 0.
  - Next cycle: rd_rvalid = 1 and rd_rdata = ram_res.
  - Read latency is exactly 1 cycle from handshake; back-to-back reads give consecutive rvalid.
- No grant:
  - ram_write = 0; ram_addr holds its last value (registered mux select).
  - ram_data is don't-care.
- Out-of-range address (>= FMINT_N_ELEM):
  - Handshake still completes.
  - Write: ram_write is suppressed.
  - Read: rd_rvalid is still asserted with rd_rdata = 0.
- Read-after-write at the same address in consecutive grants returns the new data (RAM write-first behaviour).
- clr_start handling:
  - In IDLE: enter CLEAR next cycle. Any request on the clr_start cycle is still arbitrated normally.
  - In CLEAR: ignored.
- CLEAR state:
  - clr_busy = 1; wr_ready = rd_ready = 0.
  - Each cycle: ram_addr = cnt, ram_data = 0, ram_write = 1, cnt++.
  - After cnt = FMINT_N_ELEM-1 is written: return to IDLE, pulse clr_done for one cycle (first IDLE cycle), reset cnt to 0.
  - Sweep length is exactly FMINT_N_ELEM cycles.
- Pending rd_rvalid from a read granted on the cycle before CLEAR is still delivered.
- Reset mid-sweep: abort immediately, no clr_done; RAM contents are undefined.
- prio is preserved across CLEAR.

Decomposition:
- irb_pkg holds:
  - PX_W and FMINT_N_ELEM;
  - an enum fmint_state_t {IDLE, CLEAR};
  - an enum fmint_prio_t {PRIO_WR, PRIO_RD}.
- Optional sub-module fmint_rr_arb2: 2-input round-robin grant with a priority register.
- The sweep FSM and the RAM-side mux stay in the top module.
- The RAM is instantiated by the parent, not inside this block.

Test Plan:
- Reset values: hold rst_n = 0 with random inputs. Expect all outputs 0 and ready low. Release, then wr_valid = 1 alone gives wr_ready = 1 the same cycle.
- Write/read round trip: write 0x1234 to addr 5, then read addr 5. Expect ram_write pulse at addr 5; rd_rvalid exactly 1 cycle after the read handshake with rd_rdata = 0x1234.
- Contention: hold wr_valid and rd_valid for 6 cycles. Expect grants W,R,W,R,W,R (writer first after reset); never both ready high.
- Clear sweep: after filling addr 0..7 with 0xFFFF, pulse clr_start. Expect:
  - clr_busy for exactly FMINT_N_ELEM cycles with ram_addr running 0..FMINT_N_ELEM-1 and ram_data = 0;
  - requests stalled throughout;
  - clr_done pulse on the first IDLE cycle;
  - reading addr 3 afterwards returns 0.
- Out of range: write addr FMINT_N_ELEM gives handshake with ram_write = 0. Read addr FMINT_N_ELEM+1 gives rd_rvalid with rd_rdata = 0.
- Reset mid-sweep: assert rst_n = 0 at cnt = 100. Expect clr_busy to drop asynchronously and no clr_done. After release, the arbiter is in IDLE with prio = WR.
